// File: rtl/note_sequencer.sv
// Multi-slot note step recorder/player: IDLE/REC/PLAY FSM, SLOTS x DEPTH note store, TICK_CYCLES per step.
// Registered note_out/step outputs; start is accepted only while idle, and stop aborts a run on the next cycle.
module note_sequencer #(
  parameter int DEPTH       = 8,
  parameter int SLOTS       = 3,
  parameter int NOTE_W      = 4,
  parameter int TICK_CYCLES = 25_000_000,
  localparam int SW         = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [SW-1:0]     slot_sel,
  input  logic              mode_rec,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [NOTE_W-1:0] note_out,
  output logic              busy,
  output logic              step_pulse,
  output logic [AW-1:0]     step_idx,
  output logic              done,
  input  logic [SW-1:0]     disp_slot,
  input  logic [AW-1:0]     disp_addr,
  output logic [NOTE_W-1:0] disp_note
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0] LAST_STEP = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [AW-1:0]     step_q, step_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              done_q, done_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              wr_en;
  logic              slot_ok;

  logic [NOTE_W-1:0] mem_q [SLOTS][DEPTH];

  assign slot_ok = 32'(slot_sel) < SLOTS;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    note_d  = '0;

    case (state_q)
      S_IDLE: begin
        step_d = '0;
        cnt_d  = '0;
        // stop in the same cycle as start suppresses the launch
        if (start && !stop && slot_ok) begin
          state_d = mode_rec ? S_REC : S_PLAY;
          slot_d  = slot_sel;
          cnt_d   = TICK_LAST;
          pulse_d = 1'b1;
        end
      end
      default: begin
        if (stop) begin
          state_d = S_IDLE;
          step_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          wr_en = (state_q == S_REC);
          if (step_q != LAST_STEP) begin
            step_d  = step_q + AW'(1);
            cnt_d   = TICK_LAST;
            pulse_d = 1'b1;
          end else if (state_q == S_PLAY && loop_en) begin
            step_d  = '0;
            cnt_d   = TICK_LAST;
            pulse_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            step_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
    endcase

    // Playback prefetches the upcoming step's note so it appears on the step's first cycle.
    case (state_d)
      S_REC:   note_d = note_in;
      S_PLAY:  note_d = mem_q[slot_d][step_d];
      default: note_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      note_q  <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        for (int a = 0; a < DEPTH; a++) begin
          mem_q[s][a] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      note_q  <= note_d;
      if (wr_en) begin
        mem_q[slot_q][step_q] <= note_in;
      end
    end
  end

  always_comb begin
    disp_note = '0;
    if (32'(disp_slot) < SLOTS) begin
      disp_note = mem_q[disp_slot][disp_addr];
    end
  end

  assign note_out   = note_q;
  assign busy       = (state_q != S_IDLE);
  assign step_pulse = pulse_q;
  assign step_idx   = step_q;
  assign done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: vector table, directed run scenarios, and random traffic against a position-count model.
module tb_note_sequencer;
  localparam int DEPTH = 8;
  localparam int SLOTS = 3;
  localparam int T     = 4;

  logic       clock = 1'b0;
  logic       reset, start, stop, mode_rec, loop_en;
  logic [3:0] note_in;
  logic [1:0] slot_sel, disp_slot;
  logic [2:0] disp_addr;
  logic [3:0] note_out, disp_note;
  logic       busy, step_pulse, done;
  logic [2:0] step_idx;

  always #5 clock = ~clock;

  note_sequencer #(.DEPTH(8), .SLOTS(3), .NOTE_W(4), .TICK_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .note_in(note_in), .slot_sel(slot_sel),
    .mode_rec(mode_rec), .loop_en(loop_en), .start(start), .stop(stop),
    .note_out(note_out), .busy(busy), .step_pulse(step_pulse), .step_idx(step_idx),
    .done(done), .disp_slot(disp_slot), .disp_addr(disp_addr), .disp_note(disp_note)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a run is a position count 0..DEPTH*T-1 since start; step = pos/T.
  int m_mem [SLOTS][DEPTH];
  bit m_busy, m_rec, m_pulse, m_done;
  int m_slot, m_pos, m_note;
  int busy_cnt, pulse_cnt, done_cnt;

  typedef struct {
    logic       rst, st, sp;
    logic [1:0] sel;
    logic       rec;
    logic       e_busy, e_pulse;
    logic [2:0] e_idx;
    logic [3:0] e_note;
    logic       e_done;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_disp(input logic [1:0] s, input logic [2:0] a);
    if (int'(s) >= SLOTS) return 4'd0;
    return 4'(m_mem[s][a]);
  endfunction

  task automatic model_update();
    m_pulse = 1'b0;
    m_done  = 1'b0;
    if (reset) begin
      for (int s = 0; s < SLOTS; s++)
        for (int a = 0; a < DEPTH; a++) m_mem[s][a] = 0;
      m_busy = 1'b0;
      m_pos  = 0;
    end else if (!m_busy) begin
      if (start && !stop && int'(slot_sel) < SLOTS) begin
        m_busy  = 1'b1;
        m_rec   = mode_rec;
        m_slot  = int'(slot_sel);
        m_pos   = 0;
        m_pulse = 1'b1;
      end
    end else if (stop) begin
      m_busy = 1'b0;
    end else begin
      if (m_rec && (m_pos % T) == T - 1) m_mem[m_slot][m_pos / T] = int'(note_in);
      if (m_pos == DEPTH * T - 1) begin
        if (!m_rec && loop_en) begin
          m_pos   = 0;
          m_pulse = 1'b1;
        end else begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        m_pos++;
        m_pulse = ((m_pos % T) == 0);
      end
    end
    if (!m_busy) m_pos = 0;
    m_note = !m_busy ? 0 : (m_rec ? int'(note_in) : m_mem[m_slot][m_pos / T]);
  endtask

  task automatic clk_cycle();
    #1;
    chk("disp_note", disp_note, m_disp(disp_slot, disp_addr));
    model_update();
    @(posedge clock);
    #1;
    chk("note_out", note_out, m_note);
    chk("busy", busy, m_busy);
    chk("step_pulse", step_pulse, m_pulse);
    chk("step_idx", step_idx, m_busy ? m_pos / T : 0);
    chk("done", done, m_done);
    if (busy) busy_cnt++;
    if (step_pulse) pulse_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    pulse_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode_rec = 1'b0; loop_en = 1'b0;
    note_in = 4'hA; slot_sel = 2'd0; disp_slot = 2'd0; disp_addr = 3'd0;
    clear_counts();
    @(posedge clock);
    #1;
    model_update();

    //             rst st sp sel  rec  busy pls idx note done
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 3'd1, 4'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      reset = vecs[i].rst; start = vecs[i].st; stop = vecs[i].sp;
      slot_sel = vecs[i].sel; mode_rec = vecs[i].rec;
      clk_cycle();
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_pulse", step_pulse, vecs[i].e_pulse);
      chk("vec_idx", step_idx, vecs[i].e_idx);
      chk("vec_note", note_out, vecs[i].e_note);
      chk("vec_done", done, vecs[i].e_done);
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0;

    // Record slot 1 with note = step+1.
    slot_sel = 2'd1; mode_rec = 1'b1; start = 1'b1;
    clear_counts();
    clk_cycle();
    start = 1'b0;
    chk("rec_first_pulse", step_pulse, 1);
    for (int k = 0; k < 32; k++) begin
      note_in = 4'(k / 4 + 1);
      clk_cycle();
      chk("rec_pulse", step_pulse, (k % 4 == 3) && (k != 31));
    end
    chk("rec_busy_cycles", busy_cnt, 32);
    chk("rec_pulses", pulse_cnt, 8);
    chk("rec_done_count", done_cnt, 1);
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < DEPTH; a++) begin
        disp_slot = 2'(s); disp_addr = 3'(a);
        #1;
        chk("rec_disp", disp_note, (s == 1) ? a + 1 : 0);
      end
    end

    // Play slot 1 once; slot_sel/mode_rec changes mid-run must not matter.
    slot_sel = 2'd1; mode_rec = 1'b0; loop_en = 1'b0; start = 1'b1;
    clear_counts();
    clk_cycle();
    start = 1'b0;
    chk("play_note", note_out, 1);
    for (int k = 1; k < 32; k++) begin
      if (k == 2) begin slot_sel = 2'd2; mode_rec = 1'b1; note_in = 4'hF; end
      clk_cycle();
      chk("play_note", note_out, k / 4 + 1);
      chk("play_idx", step_idx, k / 4);
    end
    clk_cycle();
    chk("play_end_note", note_out, 0);
    chk("play_end_done", done, 1);
    chk("play_end_busy", busy, 0);
    clk_cycle();
    chk("play_done_once", done_cnt, 1);

    // Looping play, loop_en dropped during step 5 of pass 2.
    begin
      int n;
      slot_sel = 2'd1; mode_rec = 1'b0; loop_en = 1'b1; start = 1'b1;
      clear_counts();
      clk_cycle();
      start = 1'b0;
      n = 0;
      while (busy && n < 200) begin
        if (n == 52) loop_en = 1'b0;
        clk_cycle();
        n++;
        if (n == 32) begin
          chk("wrap_pulse", step_pulse, 1);
          chk("wrap_idx", step_idx, 0);
          chk("wrap_busy", busy, 1);
          chk("wrap_note", note_out, 1);
        end
      end
      chk("loop_timeout", n < 200, 1);
      chk("loop_len", n, 64);
      chk("loop_busy_cycles", busy_cnt, 64);
      chk("loop_pulses", pulse_cnt, 16);
      chk("loop_done", done_cnt, 1);
    end

    // Record slot 2, stop on the last cycle of step 3.
    slot_sel = 2'd2; mode_rec = 1'b1; loop_en = 1'b0; start = 1'b1;
    clear_counts();
    clk_cycle();
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      note_in = 4'(k / 4 + 5);
      clk_cycle();
    end
    note_in = 4'hC; stop = 1'b1;
    clk_cycle();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_note", note_out, 0);
    clk_cycle();
    chk("stop_no_done", done_cnt, 0);
    for (int a = 0; a < DEPTH; a++) begin
      disp_slot = 2'd2; disp_addr = 3'(a);
      #1;
      chk("stop_disp2", disp_note, (a < 3) ? a + 5 : 0);
      disp_slot = 2'd1;
      #1;
      chk("stop_disp1", disp_note, a + 1);
    end

    // Reset during play step 4.
    slot_sel = 2'd1; mode_rec = 1'b0; start = 1'b1;
    clear_counts();
    clk_cycle();
    start = 1'b0;
    for (int k = 0; k < 16; k++) clk_cycle();
    chk("rst_pre_idx", step_idx, 4);
    reset = 1'b1;
    clk_cycle();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_note", note_out, 0);
    chk("rst_pulse", step_pulse, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_done", done, 0);
    for (int s = 0; s < SLOTS; s++) begin
      for (int a = 0; a < DEPTH; a++) begin
        disp_slot = 2'(s); disp_addr = 3'(a);
        #1;
        chk("rst_disp", disp_note, 0);
      end
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 79) == 0);
      slot_sel = 2'($urandom_range(0, 3));
      mode_rec = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) loop_en = ~loop_en;
      note_in   = 4'($urandom);
      disp_slot = 2'($urandom_range(0, 3));
      disp_addr = 3'($urandom_range(0, 7));
      clk_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
